// File: rtl/run_sched.sv
// run_sched: round-robin owner of a single shared run counter.
// A winning requester gets one counting run from 0 up to its latched
// terminal count, optionally cut short by abort, followed by a one-cycle
// done pulse that reports who finished and whether the run was aborted.
module run_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 32
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*CW-1:0]       len,
  input  logic                     abort,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic [CW-1:0]            count,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     aborted
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   own;      // requester that owns the current/last run
  logic [IW-1:0]   last;     // previous grantee, search starts after it
  logic [IW-1:0]   winner;
  logic [CW-1:0]   len_q;
  logic            ab_q;     // current run was terminated by abort
  logic            at_end;
  logic [CW-1:0]   len_arr [NREQ];

  // Round-robin search: first requester after 'from_last', wrapping.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   from_last);
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(from_last) + k) % NREQ);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign len_arr[g] = len[g*CW +: CW];
  end

  assign winner = rr_pick(req, last);
  assign at_end = (count == len_q);

  // State register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and output decode; grant/done are pure functions of state.
  always_comb begin
    state_nxt = state;
    grant     = '0;
    busy      = 1'b0;
    done      = 1'b0;
    done_id   = '0;
    aborted   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) state_nxt = RUN;
      end
      RUN: begin
        grant[own] = 1'b1;
        busy       = 1'b1;
        // abort wins over a simultaneous terminal count
        if (abort || at_end) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        done_id   = own;
        aborted   = ab_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run bookkeeping: owner capture, length latch, counting, abort flag.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      own   <= '0;
      last  <= IW'(NREQ - 1);
      len_q <= '0;
      count <= '0;
      ab_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            own   <= winner;
            len_q <= len_arr[winner];
            count <= '0;
            ab_q  <= 1'b0;
          end
        end
        RUN: begin
          // count freezes on abort and saturates at len_q (no wrap)
          if (abort)        ab_q  <= 1'b1;
          else if (!at_end) count <= count + CW'(1);
        end
        FIN: begin
          last <= own;
        end
        default: ;
      endcase
    end
  end

endmodule
